// File: rtl/rf_arb_pkg.sv
// Shared constants and the issue-register layout for the register-file port arbiter.
// Widths here fix the default AW/DW of rf_port_arb; DW must stay 16 (two byte lanes).
package rf_arb_pkg;

    localparam int RF_AW = 4;
    localparam int RF_DW = 16;

    localparam int REQ_WB = 0;
    localparam int REQ_LD = 1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [1:0] BEN_NONE = 2'b00;
    localparam logic [1:0] BEN_LO   = 2'b01;
    localparam logic [1:0] BEN_HI   = 2'b10;
    localparam logic [1:0] BEN_WORD = 2'b11;

    typedef struct packed {
        logic             valid;
        logic             owner;
        logic             we;
        logic [RF_AW-1:0] sel;
        logic [RF_DW-1:0] wdata;
        logic [1:0]       ben;
    } iss_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rf_port_arb_if.sv
// Requester-side and port-B handshake bundle of the register-file port arbiter.
// master = requesters / datapath, slave = arbiter.
interface rf_port_arb_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] sel0;
    logic [AW-1:0] sel1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    ben0;
    logic [1:0]    ben1;
    logic [1:0]    gnt;
    logic [DW-1:0] rdata;
    logic [1:0]    rvalid;
    logic          b_req;
    logic [AW-1:0] b_sel;
    logic          b_stall;

    modport master (
        output req, we, sel0, sel1, wdata0, wdata1, ben0, ben1, b_req, b_sel,
        input  gnt, rdata, rvalid, b_stall
    );

    modport slave (
        input  req, we, sel0, sel1, wdata0, wdata1, ben0, ben1, b_req, b_sel,
        output gnt, rdata, rvalid, b_stall
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; combinational winner, pointer flop updates on contest only.
// A lone eligible requester wins without disturbing the pointer.
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    output logic [1:0] winner,
    output logic       ptr_nxt
);

    // Index of the requester that wins the next two-way contest.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        winner = 2'b00;
        ptr_d  = ptr_q;
        if (eligible[REQ_WB] && eligible[REQ_LD]) begin
            winner = owner_onehot(ptr_q);
            ptr_d  = ~ptr_q;
        end else begin
            winner = eligible;
        end
    end

    assign ptr_nxt = ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_port_arb.sv
// Shares register-file port A between ALU writeback and load/IO; guards port B against same-cycle writes.
// Grant one cycle after req, read data/rvalid one cycle after grant; requesters hold req until gnt.
module rf_port_arb
    import rf_arb_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
)(
    input  logic          clk,
    input  logic          reset,
    rf_port_arb_if.slave  bus,
    output logic [AW-1:0] rf_selA,
    output logic [AW-1:0] rf_selB,
    output logic [DW-1:0] rf_dataIn,
    output logic [1:0]    rf_enable,
    input  logic [DW-1:0] rf_dataOutA
);

    iss_t          iss_q;
    iss_t          iss_d;
    logic [AW-1:0] sel_a_q;
    logic [AW-1:0] sel_a_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic [1:0]    rvalid_q;
    logic [1:0]    rvalid_d;

    logic [1:0]    gnt;
    logic [1:0]    eligible;
    logic [1:0]    winner;
    logic          ptr_unused;
    logic          rd_cyc;
    logic          wr_cyc;

    assign gnt      = iss_q.valid ? owner_onehot(iss_q.owner) : 2'b00;
    // A requester being granted this cycle still shows req; exclude it so it is not granted twice.
    assign eligible = bus.req & ~gnt;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .winner   (winner),
        .ptr_nxt  (ptr_unused)
    );

    always_comb begin
        iss_d   = '0;
        sel_a_d = sel_a_q;
        if (winner[REQ_WB]) begin
            iss_d.valid = 1'b1;
            iss_d.owner = 1'(REQ_WB);
            iss_d.we    = bus.we[REQ_WB];
            iss_d.sel   = bus.sel0;
            iss_d.wdata = bus.wdata0;
            iss_d.ben   = bus.ben0;
        end else if (winner[REQ_LD]) begin
            iss_d.valid = 1'b1;
            iss_d.owner = 1'(REQ_LD);
            iss_d.we    = bus.we[REQ_LD];
            iss_d.sel   = bus.sel1;
            iss_d.wdata = bus.wdata1;
            iss_d.ben   = bus.ben1;
        end
        // Port A address is held across idle cycles.
        if (iss_d.valid) begin
            sel_a_d = iss_d.sel;
        end
    end

    assign rd_cyc = iss_q.valid && (iss_q.we == OP_RD);
    assign wr_cyc = iss_q.valid && (iss_q.we == OP_WR);

    always_comb begin
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        if (rd_cyc) begin
            rvalid_d = gnt;
            rdata_d  = rf_dataOutA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_q    <= '0;
            sel_a_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
        end else begin
            iss_q    <= iss_d;
            sel_a_q  <= sel_a_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rf_selA   = sel_a_q;
    assign rf_selB   = bus.b_sel;
    assign rf_dataIn = iss_q.wdata;
    assign rf_enable = wr_cyc ? iss_q.ben : BEN_NONE;

    assign bus.gnt    = gnt;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    // A zero-enable write never touches the file, so it cannot corrupt a port B read.
    assign bus.b_stall = bus.b_req && wr_cyc && (iss_q.ben != BEN_NONE) && (iss_q.sel == bus.b_sel);

endmodule

// File: tb/tb_rf_port_arb.sv
// Directed table-driven bench for rf_port_arb with a behavioural 16x16 byte-enabled register file.
module tb_rf_port_arb;
    import rf_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_init;
    logic [3:0]  rf_selA;
    logic [3:0]  rf_selB;
    logic [15:0] rf_dataIn;
    logic [1:0]  rf_enable;
    logic [15:0] rf_dataOutA;
    logic [15:0] dout_b;
    logic [15:0] mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    rf_port_arb_if #(.AW(4), .DW(16)) bus ();

    rf_port_arb #(.AW(4), .DW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .rf_selA     (rf_selA),
        .rf_selB     (rf_selB),
        .rf_dataIn   (rf_dataIn),
        .rf_enable   (rf_enable),
        .rf_dataOutA (rf_dataOutA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= (i == 5) ? 16'h1234 : (i == 7) ? 16'h0707 : 16'h0000;
            end
        end else begin
            if (rf_enable[0]) mem[rf_selA][7:0]  <= rf_dataIn[7:0];
            if (rf_enable[1]) mem[rf_selA][15:8] <= rf_dataIn[15:8];
        end
    end

    assign rf_dataOutA = mem[rf_selA];
    assign dout_b      = mem[rf_selB];

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [3:0]  sel0;
        logic [3:0]  sel1;
        logic [15:0] wd0;
        logic [15:0] wd1;
        logic [1:0]  ben0;
        logic [1:0]  ben1;
        logic        b_req;
        logic [3:0]  b_sel;
        logic [1:0]  e_gnt;
        logic [1:0]  e_en;
        logic [3:0]  e_sela;
        logic [15:0] e_din;
        logic [1:0]  e_rv;
        logic [15:0] e_rd;
        logic        e_stall;
        logic [15:0] e_doutb;
    } vec_t;

    vec_t vec [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req    = v.req;
        bus.we     = v.we;
        bus.sel0   = v.sel0;
        bus.sel1   = v.sel1;
        bus.wdata0 = v.wd0;
        bus.wdata1 = v.wd1;
        bus.ben0   = v.ben0;
        bus.ben1   = v.ben1;
        bus.b_req  = v.b_req;
        bus.b_sel  = v.b_sel;
    endtask

    task automatic drive_idle();
        bus.req = 2'b00; bus.we = 2'b00; bus.sel0 = 4'd0; bus.sel1 = 4'd0;
        bus.wdata0 = 16'h0; bus.wdata1 = 16'h0; bus.ben0 = BEN_NONE; bus.ben1 = BEN_NONE;
        bus.b_req = 1'b0; bus.b_sel = 4'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           req    we     s0 s1 wd0       wd1       ben0      ben1      br  bs    gnt    en        selA din       rv     rdata     stl   doutB
        vec[0]  = '{2'b01, 2'b01, 3, 0, 16'hBEEF, 16'h0000, BEEF_W(), BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 0, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0};
        vec[1]  = '{2'b01, 2'b01, 3, 0, 16'hBEEF, 16'h0000, BEN_WORD, BEN_NONE, 1'b0, 0, 2'b01, BEN_WORD, 3, 16'hBEEF, 2'b00, 16'h0000, 1'b0, 16'h0};
        vec[2]  = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 3, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0};
        vec[3]  = '{2'b10, 2'b00, 0, 3, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 3, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0};
        vec[4]  = '{2'b10, 2'b00, 0, 3, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b10, BEN_NONE, 3, 16'h0000, 2'b00, 16'h0000, 1'b0, 16'h0};
        vec[5]  = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 3, 16'h0000, 2'b10, 16'hBEEF, 1'b0, 16'h0};
        vec[6]  = '{2'b11, 2'b11, 1, 2, 16'h1111, 16'h2222, BEN_WORD, BEN_WORD, 1'b0, 0, 2'b00, BEN_NONE, 3, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[7]  = '{2'b11, 2'b11, 1, 2, 16'h1111, 16'h2222, BEN_WORD, BEN_WORD, 1'b0, 0, 2'b01, BEN_WORD, 1, 16'h1111, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[8]  = '{2'b11, 2'b11, 1, 2, 16'h1111, 16'h2222, BEN_WORD, BEN_WORD, 1'b0, 0, 2'b10, BEN_WORD, 2, 16'h2222, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[9]  = '{2'b11, 2'b11, 1, 2, 16'h1111, 16'h2222, BEN_WORD, BEN_WORD, 1'b0, 0, 2'b01, BEN_WORD, 1, 16'h1111, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[10] = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b10, BEN_WORD, 2, 16'h2222, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[11] = '{2'b11, 2'b11, 1, 2, 16'h1111, 16'h2222, BEN_WORD, BEN_WORD, 1'b0, 0, 2'b00, BEN_NONE, 2, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[12] = '{2'b01, 2'b11, 1, 2, 16'h1111, 16'h2222, BEN_WORD, BEN_WORD, 1'b0, 0, 2'b10, BEN_WORD, 2, 16'h2222, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[13] = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b01, BEN_WORD, 1, 16'h1111, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[14] = '{2'b01, 2'b01, 5, 0, 16'hAA55, 16'h0000, BEN_LO,   BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 1, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[15] = '{2'b01, 2'b01, 5, 0, 16'hAA55, 16'h0000, BEN_LO,   BEN_NONE, 1'b0, 0, 2'b01, BEN_LO,   5, 16'hAA55, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[16] = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b1, 5, 2'b00, BEN_NONE, 5, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h1255};
        vec[17] = '{2'b01, 2'b01, 5, 0, 16'hFFFF, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 5, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[18] = '{2'b01, 2'b01, 5, 0, 16'hFFFF, 16'h0000, BEN_NONE, BEN_NONE, 1'b1, 5, 2'b01, BEN_NONE, 5, 16'hFFFF, 2'b00, 16'hBEEF, 1'b0, 16'h1255};
        vec[19] = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b1, 5, 2'b00, BEN_NONE, 5, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h1255};
        vec[20] = '{2'b01, 2'b01, 7, 0, 16'h7777, 16'h0000, BEN_WORD, BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 5, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[21] = '{2'b01, 2'b01, 7, 0, 16'h7777, 16'h0000, BEN_WORD, BEN_NONE, 1'b1, 7, 2'b01, BEN_WORD, 7, 16'h7777, 2'b00, 16'hBEEF, 1'b1, 16'h0};
        vec[22] = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b1, 7, 2'b00, BEN_NONE, 7, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h7777};
        vec[23] = '{2'b01, 2'b01, 7, 0, 16'h7A7A, 16'h0000, BEN_HI,   BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 7, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[24] = '{2'b01, 2'b01, 7, 0, 16'h7A7A, 16'h0000, BEN_HI,   BEN_NONE, 1'b1, 6, 2'b01, BEN_HI,   7, 16'h7A7A, 2'b00, 16'hBEEF, 1'b0, 16'h0000};
        vec[25] = '{2'b10, 2'b00, 0, 7, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b1, 7, 2'b00, BEN_NONE, 7, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h7A77};
        vec[26] = '{2'b10, 2'b00, 0, 7, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b10, BEN_NONE, 7, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 16'h0};
        vec[27] = '{2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, BEN_NONE, BEN_NONE, 1'b0, 0, 2'b00, BEN_NONE, 7, 16'h0000, 2'b10, 16'h7A77, 1'b0, 16'h0};

        // Reset with both requesters asserting and a port B read pending: nothing may be granted.
        reset    = 1'b1;
        mem_init = 1'b1;
        drive_idle();
        bus.req   = 2'b11;
        bus.b_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",    32'(bus.gnt),     32'h0);
        chk("rst_rvalid", 32'(bus.rvalid),  32'h0);
        chk("rst_rdata",  32'(bus.rdata),   32'h0);
        chk("rst_en",     32'(rf_enable),   32'h0);
        chk("rst_selA",   32'(rf_selA),     32'h0);
        chk("rst_din",    32'(rf_dataIn),   32'h0);
        chk("rst_stall",  32'(bus.b_stall), 32'h0);

        reset    = 1'b0;
        mem_init = 1'b0;
        for (int i = 0; i < 28; i++) begin
            drive(vec[i]);
            #1;
            chk($sformatf("v%0d_gnt", i),    32'(bus.gnt),     32'(vec[i].e_gnt));
            chk($sformatf("v%0d_en", i),     32'(rf_enable),   32'(vec[i].e_en));
            chk($sformatf("v%0d_selA", i),   32'(rf_selA),     32'(vec[i].e_sela));
            chk($sformatf("v%0d_din", i),    32'(rf_dataIn),   32'(vec[i].e_din));
            chk($sformatf("v%0d_rvalid", i), 32'(bus.rvalid),  32'(vec[i].e_rv));
            chk($sformatf("v%0d_rdata", i),  32'(bus.rdata),   32'(vec[i].e_rd));
            chk($sformatf("v%0d_stall", i),  32'(bus.b_stall), 32'(vec[i].e_stall));
            if (vec[i].b_req && !vec[i].e_stall) begin
                chk($sformatf("v%0d_doutB", i), 32'(dout_b), 32'(vec[i].e_doutb));
                chk($sformatf("v%0d_selB", i),  32'(rf_selB), 32'(vec[i].b_sel));
            end
            next_cycle();
        end

        // Reset lands on the cycle a read is granted; the held request must be re-granted afterwards.
        drive_idle();
        bus.req  = 2'b10;
        bus.sel1 = 4'd2;
        next_cycle();
        chk("mid_gnt", 32'(bus.gnt), 32'h2);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        chk("mid_rst_gnt",    32'(bus.gnt),    32'h0);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("mid_rst_rdata",  32'(bus.rdata),  32'h0);
        chk("mid_rst_en",     32'(rf_enable),  32'h0);
        chk("mid_rst_selA",   32'(rf_selA),    32'h0);
        next_cycle();
        chk("mid_regnt",        32'(bus.gnt),    32'h2);
        chk("mid_regnt_rvalid", 32'(bus.rvalid), 32'h0);
        chk("mid_regnt_selA",   32'(rf_selA),    32'h2);
        bus.req = 2'b00;
        next_cycle();
        chk("mid_done_rvalid", 32'(bus.rvalid), 32'h2);
        chk("mid_done_rdata",  32'(bus.rdata),  32'h2222);
        chk("mid_done_gnt",    32'(bus.gnt),    32'h0);
        next_cycle();
        chk("mid_after_rvalid", 32'(bus.rvalid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [1:0] BEEF_W();
        return BEN_WORD;
    endfunction

endmodule
